// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined), 2-flop input sync, mid-bit sampling.
// Latency: byte/valid appear one clock after the mid-stop-bit sample (~2 clks sync + 9.5 bit times after line fall).
// Backpressure: none; the consumer must capture uart_rx_data on the uart_rx_valid pulse, a newer byte overwrites it.
module uart_rx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] uart_rx_data,
   output logic       uart_rx_valid,
   output logic       uart_rx_frame_err,
   output logic       uart_rx_parity_err,
   output logic       uart_rx_busy
);

   // Start-bit sample sits half a bit after the detected falling edge.
   localparam int         HALF_BIT = CLKS_PER_BIT / 2;
   localparam logic [7:0] HALF_TGT = 8'(HALF_BIT - 1);
   localparam logic [7:0] BIT_TGT  = 8'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;
`endif

   state_t     state;
   state_t     state_nxt;
   logic       rx_meta;
   logic       rxs;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;
   logic [7:0] tgt;
   logic       tick;
   logic [2:0] bit_idx;
   logic [2:0] bit_idx_nxt;
   logic [7:0] shreg;
   logic [7:0] shreg_nxt;
   logic [7:0] data_nxt;
   logic       valid_nxt;
   logic       ferr_nxt;
`ifdef UART_RX_PARITY_EN
   logic       par_q;
   logic       par_nxt;
   logic       perr_q;
   logic       perr_nxt;
`endif

   // Two-flop synchronizer for the asynchronous line; idles high so reset cannot fake a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= uart_rxd;
         rxs     <= rx_meta;
      end
   end

   // Bit-timer target: half a bit for the start bit, a full bit everywhere else.
   always_comb begin
      tgt = BIT_TGT;
      if (state == START) begin
         tgt = HALF_TGT;
      end
   end

   assign tick = (state != IDLE) && (cnt == tgt);

   // Next-state, bit timer, shift register and pulse generation.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = (state == IDLE) ? 8'd0 : cnt + 8'd1;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      data_nxt    = uart_rx_data;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt     = par_q;
      perr_nxt    = 1'b0;
`endif
      if (tick) begin
         cnt_nxt = 8'd0;
      end

      case (state)
         IDLE: begin
            if (!rxs) begin
               state_nxt = START;
            end
         end
         START: begin
            if (tick) begin
               // A line that is high again at mid start bit was only a glitch.
               if (rxs) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt   = DATA;
                  bit_idx_nxt = 3'd0;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shreg_nxt[bit_idx] = rxs;
               bit_idx_nxt        = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               par_nxt   = rxs;
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (rxs) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                  // Even parity: data bits plus parity bit must XOR to zero.
                  perr_nxt  = (^shreg) ^ par_q;
`endif
                  state_nxt = IDLE;
               end else begin
                  // Frame error suppresses both the byte and any parity report.
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // Hold off new frames until a break / stuck-low line releases.
            if (rxs) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Every state entry restarts the bit timer.
      if (state_nxt != state) begin
         cnt_nxt = 8'd0;
      end
   end

   // State, datapath and registered output pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         cnt               <= 8'd0;
         bit_idx           <= 3'd0;
         shreg             <= 8'h00;
         uart_rx_data      <= 8'h00;
         uart_rx_valid     <= 1'b0;
         uart_rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q             <= 1'b0;
         perr_q            <= 1'b0;
`endif
      end else begin
         state             <= state_nxt;
         cnt               <= cnt_nxt;
         bit_idx           <= bit_idx_nxt;
         shreg             <= shreg_nxt;
         uart_rx_data      <= data_nxt;
         uart_rx_valid     <= valid_nxt;
         uart_rx_frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
         par_q             <= par_nxt;
         perr_q            <= perr_nxt;
`endif
      end
   end

`ifdef UART_RX_PARITY_EN
   assign uart_rx_parity_err = perr_q;
`else
   assign uart_rx_parity_err = 1'b0;
`endif

   // Busy covers every non-idle state, including the stuck-low wait.
   assign uart_rx_busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that converts the serial line into bytes for the core logic. It is the receive-side counterpart of the UART transmitter: 8N1 framing, LSB first, same baud generation scheme (10 MHz clock, 115200 baud, 87 clocks/bit). The receiver validates the start bit, samples each bit at mid-bit, and delivers each byte with a one-cycle valid pulse. Framing errors are flagged separately.

Parameters:
CLKS_PER_BIT, 87, clock cycles per bit time; legal range 8..255
HALF_BIT, CLKS_PER_BIT/2 (integer division), offset from start-edge detection to the start-bit sample

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
uart_rxd  input  1  asynchronous serial line, idle high
uart_rx_data  output  8  last correctly received byte
uart_rx_valid  output  1  one-cycle pulse: new byte on uart_rx_data
uart_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
uart_rx_parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature)
uart_rx_busy  output  1  high while a frame is being received

Behaviour:
- Reset (rst_n low at a clk edge) sets all outputs to 0, uart_rx_data to 8'h00, synchronizer flops to 1, FSM to IDLE, and counters to 0. A reset mid-frame aborts the frame with no pulse.
- uart_rxd passes through a 2-flop synchronizer (rxs). All decisions use rxs only.
- Bit timer: an 8-bit counter, cleared on every state entry, that increments each cycle while not IDLE. A "tick" occurs when the count equals the current target; the counter then clears.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
- IDLE: busy=0. When rxs==0, go to START, set busy=1, clear the counter.
- START: target = HALF_BIT-1. On tick, sample rxs.
  - rxs==1: false start (glitch). Return to IDLE, busy=0, no pulse.
  - rxs==0: go to DATA with bit index 0.
- DATA: target = CLKS_PER_BIT-1. On each tick, shift rxs into a shift register LSB first (bit index 0 is bit 0) and increment the bit index. After index 7 is sampled, go to PARITY if enabled, otherwise to STOP.
- STOP: target = CLKS_PER_BIT-1. On tick, sample rxs.
  - rxs==1: on the next edge, load uart_rx_data from the shift register and pulse uart_rx_valid for 1 cycle. Return to IDLE; busy drops on the same edge.
  - rxs==0: pulse uart_rx_frame_err for 1 cycle. uart_rx_data is unchanged and no valid pulse is issued. Go to WAIT_HIGH.
- WAIT_HIGH (break/line-low recovery): busy=1. Go to IDLE once rxs==1.
- Timing: samples fall at HALF_BIT + k*CLKS_PER_BIT cycles after detection.
- Back-to-back frames: a start edge one cycle after STOP returns to IDLE must be accepted. No idle gap beyond the stop bit is required.
- Valid, frame_err and parity_err never pulse in the same cycle, except valid together with parity_err.
- There is no backpressure. The consumer must capture data on the valid pulse; a newer byte overwrites uart_rx_data.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the frame is 8E1. A PARITY state follows DATA (target CLKS_PER_BIT-1) and samples the parity bit p.
  - If (^data)^p == 1, uart_rx_parity_err pulses in the same cycle as uart_rx_valid.
  - The byte is still delivered. A frame error takes precedence: no valid and no parity_err pulse.
- Not defined: no PARITY state and uart_rx_parity_err is tied to 0.

Test Plan:
1. 8N1 frame 0x55 at 87 clks/bit, after reset -> exactly one uart_rx_valid pulse, uart_rx_data=8'h55, busy high during the frame, no error pulses.
2. Frames 0xA3 then 0x0F back-to-back (no idle gap) -> two valid pulses about 870 cycles apart, with data 8'hA3 then 8'h0F.
3. uart_rxd low for 20 cycles then high -> no pulses, busy returns to 0 within 43 cycles, uart_rx_data unchanged.
4. Frame 0x3C with stop bit held low for 300 cycles -> one frame_err pulse, no valid, data keeps its prior value. A following 0x81 frame is received correctly.
5. rst_n asserted during data bit 4 of 0xFF -> next edge: all outputs 0, data 8'h00. A subsequent 0x12 frame is received correctly.
6. (UART_RX_PARITY_EN) 0x07 with parity bit 1 -> valid with data 8'h07, no parity_err. Same byte with parity bit 0 -> valid plus parity_err in the same cycle.
